// File: rtl/pipe_ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, memory length codes, FSM states.
package pipe_ex_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_SLT  = 4'h8;
   localparam logic [3:0] OP_SLTU = 4'h9;
   localparam logic [3:0] OP_LUI  = 4'hA;
   localparam logic [3:0] OP_MUL  = 4'hB;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MULT,
      ST_SEND,
      ST_DRAIN
   } ex_state_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; product holds the low W bits.
// Only present when PIPE_EX_MUL_EN is defined.
`ifdef PIPE_EX_MUL_EN
module ex_mul_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] product
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  acc;
   logic [W-1:0]  mcand;
   logic [W-1:0]  mplier;
   logic [CW-1:0] cnt;

   // done pulses on the edge that commits the last partial product
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(W);
            busy   <= 1'b1;
         end else if (busy) begin
            if (mplier[0])
               acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = acc;

endmodule
`endif

// File: rtl/pipe_ex.sv
// Execute stage between decode and pipeMA, 4-phase syn/ack on both sides.
// Define PIPE_EX_MUL_EN to enable the iterative MUL opcode; otherwise MUL yields 0.
module pipe_ex
   import pipe_ex_pkg::*;
#(
   parameter int DATA_L  = 32,
   parameter int MADDR_L = 32,
   parameter int OP_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_syn,
   output logic               up_ack,
   output logic               down_syn,
   input  logic               down_ack,
   input  logic [OP_W-1:0]    op,
   input  logic [DATA_L-1:0]  src1,
   input  logic [DATA_L-1:0]  src2,
   input  logic [DATA_L-1:0]  imm,
   input  logic               use_imm,
   input  logic [4:0]         rd_in,
   input  logic               mre,
   input  logic               mwe,
   input  logic [1:0]         mlen,
   input  logic               wb_in,
   output logic               re,
   output logic               we,
   output logic [1:0]         rlen,
   output logic [1:0]         wlen,
   output logic [4:0]         rd,
   output logic [MADDR_L-1:0] ex_ans,
   output logic [DATA_L-1:0]  ex_din,
   output logic               ex_wb_e
);

   localparam int SH_W = $clog2(DATA_L);

   ex_state_t         state;
   logic [OP_W-1:0]   op_q;
   logic [DATA_L-1:0] src1_q, src2_q, imm_q;
   logic              use_imm_q, mre_q, mwe_q, wb_q;
   logic [4:0]        rd_q;
   logic [1:0]        mlen_q;

   logic [DATA_L-1:0] opb, alu_res, addr;
   logic              is_mem, mul_sel;

   // ALU works on the captured instruction so inputs may change once up_ack is seen
   always_comb begin
      opb     = use_imm_q ? imm_q : src2_q;
      addr    = src1_q + imm_q;
      is_mem  = mre_q | mwe_q;
      alu_res = '0;
      case (op_q)
         OP_ADD:  alu_res = src1_q + opb;
         OP_SUB:  alu_res = src1_q - opb;
         OP_AND:  alu_res = src1_q & opb;
         OP_OR:   alu_res = src1_q | opb;
         OP_XOR:  alu_res = src1_q ^ opb;
         OP_SLL:  alu_res = src1_q << opb[SH_W-1:0];
         OP_SRL:  alu_res = src1_q >> opb[SH_W-1:0];
         OP_SRA:  alu_res = $unsigned($signed(src1_q) >>> opb[SH_W-1:0]);
         OP_SLT:  alu_res = {{(DATA_L-1){1'b0}}, ($signed(src1_q) < $signed(opb))};
         OP_SLTU: alu_res = {{(DATA_L-1){1'b0}}, (src1_q < opb)};
         OP_LUI:  alu_res = opb;
         default: alu_res = '0;
      endcase
   end

`ifdef PIPE_EX_MUL_EN
   logic              mul_start, mul_busy, mul_done;
   logic [DATA_L-1:0] mul_prod;

   assign mul_sel   = !is_mem && (op_q == OP_MUL);
   assign mul_start = (state == ST_EXEC) && mul_sel && !mul_busy;

   ex_mul_iter #(.W(DATA_L)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (src1_q),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );
`else
   assign mul_sel = 1'b0;
`endif

   // up_ack release runs beside the FSM so decode can finish its handshake during SEND
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         up_ack    <= 1'b0;
         down_syn  <= 1'b0;
         re        <= 1'b0;
         we        <= 1'b0;
         rlen      <= '0;
         wlen      <= '0;
         rd        <= '0;
         ex_ans    <= '0;
         ex_din    <= '0;
         ex_wb_e   <= 1'b0;
         op_q      <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         rd_q      <= '0;
         mre_q     <= 1'b0;
         mwe_q     <= 1'b0;
         mlen_q    <= '0;
         wb_q      <= 1'b0;
      end else begin
         if (up_ack && !up_syn)
            up_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (up_syn && !up_ack) begin
                  op_q      <= op;
                  src1_q    <= src1;
                  src2_q    <= src2;
                  imm_q     <= imm;
                  use_imm_q <= use_imm;
                  rd_q      <= rd_in;
                  mre_q     <= mre;
                  mwe_q     <= mwe;
                  mlen_q    <= mlen;
                  wb_q      <= wb_in;
                  up_ack    <= 1'b1;
                  state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rd     <= rd_q;
               ex_din <= src2_q;
               if (is_mem) begin
                  ex_ans  <= MADDR_L'(addr);
                  re      <= mre_q;
                  we      <= mwe_q;
                  rlen    <= mlen_q;
                  wlen    <= mlen_q;
                  ex_wb_e <= 1'b0;
               end else begin
                  ex_ans  <= MADDR_L'(alu_res);
                  re      <= 1'b0;
                  we      <= 1'b0;
                  rlen    <= '0;
                  wlen    <= '0;
                  ex_wb_e <= wb_q;
               end
               if (mul_sel) begin
                  state <= ST_MULT;
               end else begin
                  down_syn <= 1'b1;
                  state    <= ST_SEND;
               end
            end
`ifdef PIPE_EX_MUL_EN
            ST_MULT: begin
               if (mul_done) begin
                  ex_ans   <= MADDR_L'(mul_prod);
                  down_syn <= 1'b1;
                  state    <= ST_SEND;
               end
            end
`endif
            ST_SEND: begin
               if (down_ack) begin
                  down_syn <= 1'b0;
                  state    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!down_ack)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
